// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared types and widths for the multiplier-cluster run controller
package multicore_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } run_state_e;

    localparam int CORE_ID_W = 8;
    localparam int IM_ADDR_W = 8;
    localparam int IM_DATA_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: enabled requests -> one-hot grant, rotating pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] en_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  elig;
    logic [N-1:0]  upper;
    logic [N-1:0]  pool;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
    always_comb begin
        elig  = req_i & en_i;
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = elig[i] && (i >= int'(ptr_q));
        end
        pool = (upper != '0) ? upper : elig;
    end

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        ptr_d   = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/multicore_run_ctrl.sv
// rtl/multicore_run_ctrl.sv - launch/barrier/timeout FSM and shared instr-mem write arbitration
module multicore_run_ctrl
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int DATA_W    = IM_DATA_W,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_CORES-1:0]        core_mask,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic [NUM_CORES-1:0]        core_run,
    input  logic [NUM_CORES-1:0]        im_wr_req,
    input  logic [NUM_CORES*ADDR_W-1:0] im_wr_addr,
    input  logic [NUM_CORES*DATA_W-1:0] im_wr_data,
    output logic [NUM_CORES-1:0]        im_wr_gnt,
    output logic                        im_we,
    output logic [ADDR_W-1:0]           im_addr,
    output logic [DATA_W-1:0]           im_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    run_state_e           state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] run_q, run_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 tmo_q, tmo_d;
    logic [NUM_CORES-1:0] gnt_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;

    logic                 busy_w;
    logic                 all_done;
    logic                 tmo_hit;
    logic [NUM_CORES-1:0] arb_en;
    logic [NUM_CORES-1:0] arb_gnt;
    logic                 arb_valid;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    data_sel;

    assign busy_w   = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign all_done = ((core_done & mask_q) == mask_q);
    assign tmo_hit  = (TIMEOUT != 0) && (count_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        run_d   = run_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = core_mask;
                    count_d = '0;
                    tmo_d   = 1'b0;
                    state_d = (core_mask == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                run_d   = mask_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                run_d = run_q & ~(core_done & mask_q);
                // A completed barrier takes precedence over a timeout in the same cycle.
                if (all_done || tmo_hit) begin
                    run_d   = '0;
                    state_d = ST_DRAIN;
                    tmo_d   = !all_done;
                end
            end
            ST_DRAIN: begin
                if (((im_wr_req & mask_q) == '0) && !we_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            run_q   <= '0;
            count_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            run_q   <= run_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outside a run every request is eligible so instruction memory can be preloaded.
    assign arb_en = busy_w ? mask_q : '1;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (im_wr_req),
        .en_i    (arb_en),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (arb_gnt[k]) begin
                addr_sel = im_wr_addr[k*ADDR_W +: ADDR_W];
                data_sel = im_wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            gnt_q <= arb_gnt;
            we_q  <= arb_valid;
            if (arb_valid) begin
                addr_q <= addr_sel;
                data_q <= data_sel;
            end
        end
    end

    assign core_run    = run_q;
    assign im_wr_gnt   = gnt_q;
    assign im_we       = we_q;
    assign im_addr     = addr_q;
    assign im_wdata    = data_q;
    assign busy        = busy_w;
    assign done        = (state_q == ST_DONE);
    assign timeout_err = tmo_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// tb/tb_multicore_run_ctrl.sv - self-checking bench for multicore_run_ctrl
module tb_multicore_run_ctrl;

    localparam int NC  = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int CW  = 32;
    localparam int TMO = 20;
    localparam logic [7:0] NEVER = 8'hFF;

    typedef struct packed {
        logic [3:0]      mask;
        logic [3:0][7:0] d;
        logic [7:0]      exp_cnt;
        logic            exp_tmo;
    } run_vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [NC-1:0]    core_mask = '0;
    logic [NC-1:0]    core_done = '0;
    logic [NC-1:0]    core_run;
    logic [NC-1:0]    im_wr_req = '0;
    logic [NC*AW-1:0] im_wr_addr = '0;
    logic [NC*DW-1:0] im_wr_data = '0;
    logic [NC-1:0]    im_wr_gnt;
    logic             im_we;
    logic [AW-1:0]    im_addr;
    logic [DW-1:0]    im_wdata;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CW-1:0]    cycle_count;

    int n_cmp = 0;
    int n_err = 0;
    int pend [4];
    logic [7:0]  a_slot [4];
    logic [15:0] d_slot [4];
    int mptr = 0;
    int obs [$];
    logic last_tmo = 1'b0;
    run_vec_t vecs [16];

    multicore_run_ctrl #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .core_mask(core_mask),
        .core_done(core_done), .core_run(core_run), .im_wr_req(im_wr_req),
        .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data), .im_wr_gnt(im_wr_gnt),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
        .done(done), .timeout_err(timeout_err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Outcome of a run from the barrier/timeout rules: RUN lasts until the latest masked done.
    function automatic run_vec_t mk_vec(input logic [3:0] m, input logic [3:0][7:0] d);
        run_vec_t v;
        int b;
        b = 0;
        v.mask = m;
        v.d    = d;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && int'(d[i]) > b) b = int'(d[i]);
        end
        if (m == 4'h0) begin
            v.exp_cnt = 8'd0; v.exp_tmo = 1'b0;
        end else if (b < TMO) begin
            v.exp_cnt = 8'(b + 1); v.exp_tmo = 1'b0;
        end else begin
            v.exp_cnt = 8'(TMO); v.exp_tmo = 1'b1;
        end
        return v;
    endfunction

    task automatic do_run(input run_vec_t v);
        int cnt;
        int last_o;
        logic eb, ed, et;
        logic [3:0] er;
        int ec;
        cnt = int'(v.exp_cnt);
        chk("tmo_hold", 64'(timeout_err), 64'(last_tmo));
        start     = 1'b1;
        core_mask = v.mask;
        core_done = 4'($urandom) & ~v.mask;
        last_o    = (v.mask == 4'h0) ? 1 : cnt + 3;
        for (int o = 0; o <= last_o; o++) begin
            @(posedge clk);
            @(negedge clk);
            if (v.mask == 4'h0) begin
                eb = 1'b0; ed = (o == 0); er = 4'h0; ec = 0; et = 1'b0;
            end else begin
                eb = (o <= cnt + 1);
                ed = (o == cnt + 2);
                for (int i = 0; i < 4; i++)
                    er[i] = v.mask[i] && (o >= 1) && (o <= cnt) && ((o - 1) <= int'(v.d[i]));
                ec = (o == 0) ? 0 : ((o - 1 < cnt) ? o - 1 : cnt);
                et = (o >= cnt + 1) ? v.exp_tmo : 1'b0;
            end
            chk("busy", 64'(busy), 64'(eb));
            chk("done", 64'(done), 64'(ed));
            chk("core_run", 64'(core_run), 64'(er));
            chk("cycle_count", 64'(cycle_count), 64'(ec));
            chk("timeout_err", 64'(timeout_err), 64'(et));
            start     = (o < last_o) ? 1'($urandom) : 1'b0;
            core_mask = 4'($urandom);
            for (int i = 0; i < 4; i++)
                core_done[i] = v.mask[i] ? ((o - 1) >= int'(v.d[i])) : 1'($urandom);
        end
        start     = 1'b0;
        core_done = '0;
        last_tmo  = v.exp_tmo;
    endtask

    task automatic arb_cycle();
        logic ex_we;
        int ex_k;
        logic [7:0] ex_a;
        logic [15:0] ex_d;
        ex_we = 1'b0; ex_k = 0; ex_a = '0; ex_d = '0;
        for (int i = 0; i < 4; i++) begin
            im_wr_req[i]            = (pend[i] != 0);
            im_wr_addr[i*AW +: AW]  = a_slot[i];
            im_wr_data[i*DW +: DW]  = d_slot[i];
        end
        for (int s = 0; s < 4; s++) begin
            int c;
            c = (mptr + s) % 4;
            if (!ex_we && pend[c] != 0) begin
                ex_we = 1'b1;
                ex_k  = c;
            end
        end
        if (ex_we) begin
            ex_a = a_slot[ex_k];
            ex_d = d_slot[ex_k];
            mptr = (ex_k + 1) % 4;
        end
        @(posedge clk);
        @(negedge clk);
        chk("arb_we", 64'(im_we), 64'(ex_we));
        chk("arb_gnt", 64'(im_wr_gnt), ex_we ? (64'(1) << ex_k) : 64'(0));
        if (ex_we) begin
            chk("arb_addr", 64'(im_addr), 64'(ex_a));
            chk("arb_data", 64'(im_wdata), 64'(ex_d));
            pend[ex_k]--;
        end
        for (int i = 0; i < 4; i++) if (im_wr_gnt[i]) obs.push_back(i);
    endtask

    initial begin
        int exp_seq [5];
        logic [3:0][7:0] rd;

        vecs[0] = '{4'hF, {8'd11, 8'd8, 8'd6, 8'd4}, 8'd12, 1'b0};
        vecs[1] = '{4'h5, {NEVER, 8'd2, NEVER, 8'd2}, 8'd3, 1'b0};
        vecs[2] = '{4'h3, {NEVER, NEVER, NEVER, 8'd1}, 8'd20, 1'b1};
        vecs[3] = '{4'h1, {NEVER, NEVER, NEVER, 8'd0}, 8'd1, 1'b0};
        vecs[4] = '{4'h0, {NEVER, NEVER, NEVER, NEVER}, 8'd0, 1'b0};
        vecs[5] = '{4'h8, {8'd18, NEVER, NEVER, NEVER}, 8'd19, 1'b0};
        vecs[6] = '{4'hF, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd1, 1'b0};
        for (int k = 7; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                rd[i] = ($urandom_range(0, 5) == 0) ? NEVER : 8'($urandom_range(0, 24));
                if (rd[i] == 8'd19) rd[i] = 8'd18;
            end
            vecs[k] = mk_vec(4'($urandom), rd);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_run", 64'(core_run), 64'(0));
        chk("rst_we", 64'(im_we), 64'(0));
        chk("rst_gnt", 64'(im_wr_gnt), 64'(0));
        chk("rst_addr", 64'(im_addr), 64'(0));
        chk("rst_wdata", 64'(im_wdata), 64'(0));
        chk("rst_count", 64'(cycle_count), 64'(0));
        chk("rst_tmo", 64'(timeout_err), 64'(0));
        reset = 1'b0;

        // Preload: all four slots requesting, slot 0 twice.
        for (int i = 0; i < 4; i++) begin
            a_slot[i] = 8'(i * 16);
            d_slot[i] = 16'hA000 + 16'(i);
        end
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        obs.delete();
        repeat (6) arb_cycle();
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;
        chk("preload_count", 64'(obs.size()), 64'(5));
        for (int i = 0; i < 5 && i < obs.size(); i++) chk("preload_order", 64'(obs[i]), 64'(exp_seq[i]));

        repeat (150) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 2) == 0) begin
                    pend[i]   = $urandom_range(1, 3);
                    a_slot[i] = 8'($urandom);
                    d_slot[i] = 16'($urandom);
                end
            end
            arb_cycle();
        end
        repeat (14) arb_cycle();
        im_wr_req = '0;
        @(negedge clk);

        for (int k = 0; k < 16; k++) do_run(vecs[k]);

        // Drain: core 2 keeps requesting for three grants after the barrier.
        start = 1'b1; core_mask = 4'hF; core_done = 4'hF;
        im_wr_addr[2*AW +: AW] = 8'h5A;
        im_wr_data[2*DW +: DW] = 16'hBEEF;
        for (int o = 0; o <= 8; o++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk("drain_busy", 64'(busy), 64'(o <= 6));
            chk("drain_done", 64'(done), 64'(o == 7));
            chk("drain_we", 64'(im_we), 64'(o >= 3 && o <= 5));
            if (o >= 3 && o <= 5) begin
                chk("drain_gnt", 64'(im_wr_gnt), 64'(4'b0100));
                chk("drain_addr", 64'(im_addr), 64'(8'h5A));
                chk("drain_data", 64'(im_wdata), 64'(16'hBEEF));
            end
            im_wr_req[2] = (o >= 2 && o <= 4);
        end
        core_done = '0;
        im_wr_req = '0;
        chk("drain_count", 64'(cycle_count), 64'(1));

        // Reset mid-RUN with a write request pending on the same edge.
        start = 1'b1; core_mask = 4'hF; core_done = 4'h0;
        for (int o = 0; o <= 7; o++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_run", 64'(core_run), 64'(4'hF));
        chk("pre_rst_count", 64'(cycle_count), 64'(6));
        reset = 1'b1;
        im_wr_req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_run", 64'(core_run), 64'(0));
        chk("mid_rst_we", 64'(im_we), 64'(0));
        chk("mid_rst_gnt", 64'(im_wr_gnt), 64'(0));
        chk("mid_rst_count", 64'(cycle_count), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        reset = 1'b0;
        im_wr_req = '0;
        last_tmo = 1'b0;
        do_run(vecs[0]);
        do_run(vecs[2]);
        do_run(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
